fp_addsub_sched: RTL

- Shares one pipelined single-precision FP add/sub unit between NUM_REQ requesters in the SZ front-end stages (prediction, error computation).
- Arbitrates requests round-robin and registers the winning operands into the unit.
- Carries a requester tag alongside the unit's fixed latency and returns each result to its owner as a one-hot valid.
- The FP unit itself is external; this block only sequences and routes.

---
 rtl/fp_addsub_sched_pkg.sv | 17 +
 rtl/fp_addsub_sched_if.sv | 30 +++
 rtl/fp_addsub_sched_rr_arbiter.sv | 53 +++++
 rtl/fp_addsub_sched.sv | 98 +++++++++
 4 files changed

// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the SZ FP add/sub scheduler.
// Tag id width covers the largest supported requester count (8).
package fp_addsub_sched_pkg;

  localparam int   SZ_FP_W    = 32;
  localparam int   SZ_FP_LAT  = 7;
  localparam int   SZ_NUM_REQ = 4;
  localparam logic FP_OP_ADD  = 1'b1;
  localparam logic FP_OP_SUB  = 1'b0;
  localparam int   TAG_ID_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_addsub_sched_if.sv
// Requester-side bundle: requests in, grants and results out.
// master = requesters, slave = scheduler.
interface fp_addsub_sched_if
  import fp_addsub_sched_pkg::*;
#(
  parameter int NUM_REQ = SZ_NUM_REQ,
  parameter int FP_W    = SZ_FP_W
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_add_sub;
  logic [NUM_REQ*FP_W-1:0] req_dataa;
  logic [NUM_REQ*FP_W-1:0] req_datab;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [FP_W-1:0]         rsp_result;

  modport master (
    output req_valid, req_add_sub,
    output req_dataa, req_datab,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_add_sub,
    input  req_dataa, req_datab,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins.
// Pointer moves past the winner only when the grant is taken.
module fp_addsub_sched_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  function automatic logic [IW-1:0] f_wrap(
    input logic [IW-1:0] p,
    input int            k
  );
    int j = int'(p) + k;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return IW'(j);
  endfunction

  // search upward from the pointer with wrap
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[f_wrap(r_ptr, k)]) begin
        w_idx   = f_wrap(r_ptr, k);
        w_found = 1'b1;
      end
    end
  end

  assign o_idx   = w_idx;
  assign o_grant = (i_en && w_found) ?
                   (NUM_REQ'(1) << w_idx) : '0;

  // pointer advances past the winner on handshake only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (i_advance)
      r_ptr <= f_wrap(w_idx, 1);
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one pipelined FP add/sub unit among NUM_REQ requesters.
// A tag pipeline matching the unit latency routes results back.
module fp_addsub_sched
  import fp_addsub_sched_pkg::*;
#(
  parameter int NUM_REQ = SZ_NUM_REQ,
  parameter int FP_LAT  = SZ_FP_LAT,
  parameter int FP_W    = SZ_FP_W
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            en,
  fp_addsub_sched_if.slave bus,
  output logic            fp_add_sub,
  output logic [FP_W-1:0] fp_dataa,
  output logic [FP_W-1:0] fp_datab,
  input  logic [FP_W-1:0] fp_result,
  output logic            idle
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_hs;
  logic [NUM_REQ-1:0] w_rsp;
  logic               w_busy;
  logic               r_op;
  logic [FP_W-1:0]    r_a;
  logic [FP_W-1:0]    r_b;
  tag_t               r_tag [FP_LAT+1];

  fp_addsub_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clock),
    .rst_n     (resetn),
    .i_req     (bus.req_valid),
    .i_en      (en),
    .i_advance (w_hs),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  // grant only goes to a valid requester, so any grant is a handshake
  assign w_hs          = |w_grant;
  assign bus.req_ready = w_grant;

  // capture the winner's operands; hold them when idle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_op <= FP_OP_SUB;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_hs) begin
      r_op <= bus.req_add_sub[w_idx];
      r_a  <= bus.req_dataa[int'(w_idx)*FP_W +: FP_W];
      r_b  <= bus.req_datab[int'(w_idx)*FP_W +: FP_W];
    end
  end

  assign fp_add_sub = r_op;
  assign fp_dataa   = r_a;
  assign fp_datab   = r_b;

  // owner tags travel alongside the FP unit's latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k <= FP_LAT; k++)
        r_tag[k] <= '0;
    end else begin
      r_tag[0] <= {w_hs, TAG_ID_W'(w_idx)};
      for (int k = 1; k <= FP_LAT; k++)
        r_tag[k] <= r_tag[k-1];
    end
  end

  // decode the last tag stage into a one-hot result strobe
  always_comb begin
    w_rsp = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_rsp[i] = r_tag[FP_LAT].valid &&
                 (r_tag[FP_LAT].id == TAG_ID_W'(i));
  end

  assign bus.rsp_valid  = w_rsp;
  assign bus.rsp_result = fp_result;

  // busy while anything is in flight or being accepted
  always_comb begin
    w_busy = w_hs;
    for (int k = 0; k <= FP_LAT; k++)
      w_busy = w_busy | r_tag[k].valid;
  end

  assign idle = ~w_busy;

endmodule
